// File: rtl/fpu_sig_addsub_pipe.sv
// Pipelined significand adder/subtractor for the FPU add path.
// The result is always a magnitude; a swapped subtraction is flagged on out_neg.
module fpu_sig_addsub_pipe #(
  parameter int unsigned W     = 27,
  parameter int unsigned PIPE  = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_add,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic             out_carry,
  output logic             out_neg,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("fpu_sig_addsub_pipe: PIPE must be 1 or 2");
  end
  if (W < 4 || W > 64) begin : g_bad_width
    $error("fpu_sig_addsub_pipe: W must be in 4..64");
  end

  typedef struct packed {
    logic [W-1:0]     res;
    logic             carry;
    logic             neg;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } stage_t;

  localparam logic [W:0] One = (W+1)'(1);

  logic [W:0] sum;
  logic [W:0] diff_ab;
  logic [W:0] diff_ba;
  logic       a_ge_b;
  stage_t     s_new;

  // Carry out of a + ~b + 1 is set exactly when a >= b.
  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff_ab = {1'b0, in_a} + {1'b0, ~in_b} + One;
    diff_ba = {1'b0, in_b} + {1'b0, ~in_a} + One;
    a_ge_b  = diff_ab[W];
    s_new     = '0;
    s_new.tag = in_tag;
    if (in_add) begin
      s_new.res   = sum[W-1:0];
      s_new.carry = sum[W];
    end else if (a_ge_b) begin
      s_new.res = diff_ab[W-1:0];
    end else begin
      s_new.res = diff_ba[W-1:0];
      s_new.neg = 1'b1;
    end
    s_new.zero = (s_new.res == '0) && !s_new.carry;
  end

  logic   v0_q, v0_d;
  logic   adv0;
  logic   accept;
  stage_t s0_q, s0_d;
  logic   v_out;
  stage_t s_out;

  assign accept   = in_valid && in_ready;
  assign in_ready = !v0_q || adv0;

  always_comb begin
    v0_d = v0_q;
    s0_d = s0_q;
    if (adv0) v0_d = 1'b0;
    if (accept) begin
      v0_d = 1'b1;
      s0_d = s_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      s0_q <= '0;
    end else begin
      v0_q <= v0_d;
      s0_q <= s0_d;
    end
  end

  if (PIPE == 2) begin : g_two
    logic   v1_q, v1_d;
    stage_t s1_q, s1_d;

    assign adv0 = !v1_q || out_ready;

    always_comb begin
      v1_d = v1_q;
      s1_d = s1_q;
      if (out_ready) v1_d = 1'b0;
      if (v0_q && adv0) begin
        v1_d = 1'b1;
        s1_d = s0_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q <= 1'b0;
        s1_q <= '0;
      end else begin
        v1_q <= v1_d;
        s1_q <= s1_d;
      end
    end

    assign v_out = v1_q;
    assign s_out = s1_q;
  end else begin : g_one
    assign adv0  = out_ready;
    assign v_out = v0_q;
    assign s_out = s0_q;
  end

  assign out_valid = v_out;
  assign out_res   = s_out.res;
  assign out_carry = s_out.carry;
  assign out_neg   = s_out.neg;
  assign out_zero  = s_out.zero;
  assign out_tag   = s_out.tag;

endmodule

// File: tb/tb_fpu_sig_addsub_pipe.sv
// Bench for fpu_sig_addsub_pipe: one PIPE=1 and one PIPE=2 instance, scoreboard per instance.
module tb_fpu_sig_addsub_pipe;
  localparam int W  = 27;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  res;
    logic          carry;
    logic          neg;
    logic          zero;
    logic [TW-1:0] tag;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_a, in_b;
  logic          in_add;
  logic [TW-1:0] in_tag;
  logic [1:0]    in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    out_carry, out_neg, out_zero;
  logic [W-1:0]  out_res [2];
  logic [TW-1:0] out_tag [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  bit   rand_on = 1'b0;
  rsp_t q0[$], q1[$];
  int   a0[$], a1[$];
  rsp_t prev [2];
  bit   held [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_sig_addsub_pipe #(.W(W), .PIPE(1), .TAG_W(TW)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_add(in_add), .in_tag(in_tag),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_res(out_res[0]),
    .out_carry(out_carry[0]), .out_neg(out_neg[0]), .out_zero(out_zero[0]),
    .out_tag(out_tag[0])
  );

  fpu_sig_addsub_pipe #(.W(W), .PIPE(2), .TAG_W(TW)) u_p2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_add(in_add), .in_tag(in_tag),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_res(out_res[1]),
    .out_carry(out_carry[1]), .out_neg(out_neg[1]), .out_zero(out_zero[1]),
    .out_tag(out_tag[1])
  );

  function automatic rsp_t mk(input logic [W-1:0] res, input logic c, input logic n,
                              input logic z, input logic [TW-1:0] tag);
    rsp_t r;
    r.res = res; r.carry = c; r.neg = n; r.zero = z; r.tag = tag;
    return r;
  endfunction

  function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic add, input logic [TW-1:0] tag);
    longint unsigned s;
    rsp_t r;
    r = '0;
    r.tag = tag;
    if (add) begin
      s = longint'(a) + longint'(b);
      r.res   = W'(s);
      r.carry = s[W];
    end else if (a >= b) begin
      r.res = a - b;
    end else begin
      r.res = b - a;
      r.neg = 1'b1;
    end
    r.zero = (r.res == 0) && !r.carry;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_out(input int sel);
    rsp_t act, exp;
    int   acc;
    bit   empty;
    act = {out_res[sel], out_carry[sel], out_neg[sel], out_zero[sel], out_tag[sel]};
    if (held[sel]) begin
      checks++;
      if (!out_valid[sel] || act !== prev[sel]) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%0b %0h want v=1 %0h", sel, out_valid[sel], act,
                 prev[sel]);
      end
    end
    held[sel] = out_valid[sel] && !out_ready[sel];
    prev[sel] = act;
    if (out_valid[sel] && out_ready[sel]) begin
      checks++;
      empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        errors++;
        $display("FAIL unexpected_out[%0d]: got %0h want no result", sel, act);
      end else begin
        if (sel == 0) begin exp = q0.pop_front(); acc = a0.pop_front(); end
        else          begin exp = q1.pop_front(); acc = a1.pop_front(); end
        if (act !== exp) begin
          errors++;
          $display("FAIL result[%0d]: got %0h want %0h", sel, act, exp);
        end
        // Sampled half a cycle after the edge, so PIPE=1 shows up in the accept cycle.
        if (lat_chk) check($sformatf("latency[%0d]", sel), 64'(cyc - acc), 64'(sel));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check_out(0);
      check_out(1);
    end else begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end
  end

  task automatic send(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic add, input logic [TW-1:0] tag, input rsp_t exp);
    int n = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_add = add; in_tag = tag;
    in_valid[sel] = 1'b1;
    while (!in_ready[sel] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[sel]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout[%0d]: got in_ready=0 want 1", sel);
      in_valid[sel] = 1'b0;
      return;
    end
    if (sel == 0) q0.push_back(exp); else q1.push_back(exp);
    @(posedge clk);
    #1;
    if (sel == 0) a0.push_back(cyc); else a1.push_back(cyc);
    in_valid[sel] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic random_phase(input int sel, input int nops);
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < nops; i++) begin
          logic [W-1:0] a, b;
          logic         add;
          a   = W'($urandom);
          b   = (i % 10 == 0) ? a : W'($urandom);
          add = 1'($urandom_range(0, 1));
          send(sel, a, b, add, TW'(i), model(a, b, add, TW'(i)));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready[sel] = 1'($urandom_range(0, 1));
        end
        out_ready[sel] = 1'b1;
      end
    join
    drain();
  endtask

  logic [W-1:0] va [8] = '{27'h4000000, 27'h4000000, 27'h0000010, 27'h5A5A5A5,
                           27'h7FFFFFF, 27'h0000000, 27'h0000000, 27'h0000003};
  logic [W-1:0] vb [8] = '{27'h4000000, 27'h0000001, 27'h0000100, 27'h5A5A5A5,
                           27'h7FFFFFF, 27'h7FFFFFF, 27'h0000000, 27'h0000005};
  logic         vadd [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] vres [8] = '{27'h0000000, 27'h3FFFFFF, 27'h00000F0, 27'h0000000,
                             27'h7FFFFFE, 27'h7FFFFFF, 27'h0000000, 27'h0000008};
  logic         vc [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic         vn [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         vz [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 1'b0; in_valid = '0; out_ready = 2'b11;
    in_a = '0; in_b = '0; in_add = 1'b0; in_tag = '0;
    #12;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_outs[%0d]", s),
            64'({out_valid[s], out_res[s], out_carry[s], out_neg[s], out_zero[s], out_tag[s]}),
            64'd0);
      check($sformatf("rst_in_ready[%0d]", s), 64'(in_ready[s]), 64'd1);
    end
    #10 rst_n = 1'b1;

    // Hand-computed vectors, back-to-back, on both pipelines.
    lat_chk = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1;
      t0 = cyc;
      for (int i = 0; i < 8; i++)
        send(s, va[i], vb[i], vadd[i], TW'(i), mk(vres[i], vc[i], vn[i], vz[i], TW'(i)));
      check($sformatf("throughput[%0d]", s), 64'(cyc - t0), 64'd8);
      drain();
    end
    lat_chk = 1'b0;

    // PIPE=2 backpressure: two ops fill the pipe, a third must wait.
    @(posedge clk);
    #1 out_ready[1] = 1'b0;
    send(1, 27'h0000123, 27'h0000023, 1'b0, 4'hA, mk(27'h0000100, 1'b0, 1'b0, 1'b0, 4'hA));
    send(1, 27'h0000001, 27'h0000002, 1'b1, 4'hB, mk(27'h0000003, 1'b0, 1'b0, 1'b0, 4'hB));
    @(negedge clk);
    check("full_in_ready", 64'(in_ready[1]), 64'd0);
    fork
      send(1, 27'h0000005, 27'h0000009, 1'b0, 4'hC, mk(27'h0000004, 1'b0, 1'b1, 1'b0, 4'hC));
      begin
        repeat (5) @(posedge clk);
        #1 out_ready[1] = 1'b1;
      end
    join
    drain();

    random_phase(1, 200);
    random_phase(0, 60);

    // Asynchronous reset with two ops held in the PIPE=2 pipe.
    @(posedge clk);
    #1 out_ready[1] = 1'b0;
    send(1, 27'h0000777, 27'h0000111, 1'b1, 4'h1, model(27'h0000777, 27'h0000111, 1'b1, 4'h1));
    send(1, 27'h0000777, 27'h0000111, 1'b0, 4'h2, model(27'h0000777, 27'h0000111, 1'b0, 4'h2));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs",
          64'({out_valid[1], out_res[1], out_carry[1], out_neg[1], out_zero[1], out_tag[1]}),
          64'd0);
    q1.delete();
    a1.delete();
    #4 rst_n = 1'b1;
    out_ready[1] = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready[1]), 64'd1);
    repeat (10) @(negedge clk);
    check("post_rst_no_valid", 64'(out_valid[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_sig_addsub_pipe.md
Name: fpu_sig_addsub_pipe

Overview:
Pipelined, parametrised significand adder/subtractor for the FPU add path. It is the successor to the combinational significand add/sub stage.
- Accepts aligned significands (guard/round/sticky included) through a valid/ready handshake.
- Performs magnitude-safe subtraction: operands are swapped internally so the result is never negative, and the swap is reported.
- Produces carry, zero and sign-flip flags, with a configurable 1- or 2-stage latency.
- Sits between the exponent-align/shift stage and the normalise/round stage.

Parameters:
W, 27, significand width in bits (hidden bit + fraction + G/R/S); legal 4..64
PIPE, 1, number of register stages; legal values 1 or 2
TAG_W, 4, width of the opaque sideband tag carried alongside each operation

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operation valid
in_ready  out  1  block can accept an operation this cycle
in_a  in  W  first significand (nominally the larger-exponent operand)
in_b  in  W  second significand (already aligned)
in_add  in  1  1 = a+b, 0 = a-b
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_res  out  W  magnitude result (low W bits)
out_carry  out  1  add: bit W of the sum; sub: always 0
out_neg  out  1  sub only: 1 when in_b > in_a (operands were swapped)
out_zero  out  1  out_res == 0 and out_carry == 0
out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset is asynchronous on the falling edge of rst_n:
  - All stage valid bits clear.
  - out_res, out_carry, out_neg, out_zero and out_tag go to 0.
  - Released synchronously with clk.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - in_ready is combinational from out_ready and stage occupancy: in_ready = !v[0] || (stage 0 advances).
  - A stage advances when its successor is empty or advancing; the last stage advances when out_ready=1.
  - in_ready never depends on in_valid.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Arithmetic, computed combinationally before the stage-0 register, in full W+1 width:
  - Add: {carry,res} = a + b.
  - Sub with a >= b: res = a - b, neg = 0.
  - Sub with a < b: res = b - a, neg = 1.
  - Sub: carry is always 0.
  - Subtraction uses two's complement: x + ~y + 1. Compare a >= b using the carry out of a + ~b + 1.
  - Equal-operand sub: res = 0, neg = 0, zero = 1.
  - Add overflow wraps the low W bits and sets carry. Example: all-ones + all-ones gives res = all-ones<<1 (low W bits), carry = 1.
  - zero is computed from the registered result, equivalently before registering.
- PIPE=1:
  - Stage 0 register is the output. Latency is 1 cycle.
  - Full throughput: 1 op/cycle when out_ready stays 1.
- PIPE=2:
  - Stage 1 is a plain register copy of stage 0. Latency is 2 cycles.
  - Full throughput is sustained.
  - Up to 2 operations are in flight.
- Ordering: results leave in acceptance order; the tag stays paired with its result.
- Bubbles: a stage whose valid is 0 may hold stale data. The bench checks outputs only when out_valid=1.
- Simultaneous accept and emit with a full pipe and out_ready=1: the pipe shifts and in_ready=1. No loss, no duplication.
- Reset mid-operation: in-flight ops are discarded, and no out_valid is produced for them after reset release.
- PIPE outside {1,2} or W<4: elaboration error via generate-time assertion.

Test Plan:
1. W=27, PIPE=1, add a=0x4000000, b=0x4000000 -> one cycle later out_res=0x0000000, out_carry=1, out_neg=0, out_zero=0.
2. Sub a=0x4000000, b=0x0000001 -> out_res=0x3FFFFFF, carry=0, neg=0; then sub a=0x0000010, b=0x0000100 -> out_res=0x00000F0, neg=1.
3. Sub a=b=0x5A5A5A5 -> out_res=0, out_zero=1, out_neg=0.
4. PIPE=2: stream 8 ops with tags 0..7 back-to-back and out_ready=1 -> first out_valid 2 cycles after first accept; 8 consecutive results in tag order.
5. PIPE=2 backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready drops once 2 ops are held, outputs stay stable, no op lost or duplicated after release; also toggle out_ready randomly over 200 ops against a reference model.
6. Assert rst_n=0 asynchronously (between edges) with 2 ops in flight -> out_valid=0 and all outputs 0 immediately; after release, no stale results appear and in_ready=1.
